// File: rtl/dig_div_bank.sv
// rtl/dig_div_bank.sv - multi-tap binary clock divider with masking, resync and counted burst mode
module dig_div_bank #(
    parameter int NCH  = 4,
    parameter int BL_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NCH-1:0]  ch_en,
    input  logic            resync,
    input  logic            burst_mode,
    input  logic [BL_W-1:0] burst_len,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [NCH-1:0]  divout,
    output logic [NCH-1:0]  tick,
    output logic [NCH-1:0]  cclk
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic            mode_q;
    logic [NCH-1:0]  cnt;
    logic [NCH-1:0]  cnt_inc;
    logic [NCH-1:0]  tick_hit;
    logic [NCH-1:0]  tick_q;
    logic [BL_W:0]   run_cnt;
    logic [BL_W:0]   run_cnt_inc;
    logic [BL_W:0]   run_target;
    logic            active;

    assign active      = en && (!mode_q || state == RUN);
    assign cnt_inc     = cnt + 1'b1;
    assign run_cnt_inc = run_cnt + 1'b1;

    // Tap k rises when bit k is the lowest set bit of the next count.
    assign tick_hit = cnt_inc & (~cnt_inc + 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            cnt        <= '0;
            run_cnt    <= '0;
            run_target <= '0;
            tick_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done   <= 1'b0;
            tick_q <= active ? (tick_hit & ch_en) : '0;
            if (active) begin
                cnt <= cnt_inc;
            end

            case (state)
                IDLE: begin
                    if (en) begin
                        mode_q <= burst_mode;
                    end
                    if (mode_q) begin
                        cnt <= '0;
                    end
                    if (en && burst_mode && start && !resync) begin
                        run_target <= {burst_len, 1'b0};
                        run_cnt    <= '0;
                        cnt        <= '0;
                        tick_q     <= '0;
                        if (burst_len != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (active) begin
                        if (run_cnt_inc == run_target) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            cnt    <= '0;
                            tick_q <= '0;
                        end else begin
                            run_cnt <= run_cnt_inc;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Phase restart overrides counting; during a burst it is an abort without done.
            if (resync) begin
                cnt    <= '0;
                tick_q <= '0;
                if (state == RUN) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            end
        end
    end

    assign divout = cnt & ch_en;
    assign tick   = tick_q & ch_en;
    assign cclk   = {NCH{clk}} & tick;

endmodule

// File: tb/tb_dig_div_bank.sv
// tb/tb_dig_div_bank.sv - directed table and burst sequence bench for dig_div_bank
module tb_dig_div_bank;
    localparam int NCH  = 4;
    localparam int BL_W = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [NCH-1:0]  ch_en;
    logic            resync;
    logic            burst_mode;
    logic [BL_W-1:0] burst_len;
    logic            start;
    logic            busy;
    logic            done;
    logic [NCH-1:0]  divout;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  cclk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       en;
        logic [3:0] ch_en;
        logic       resync;
        logic [3:0] exp_div;
        logic [3:0] exp_tick;
    } vec_t;

    vec_t vecs [0:23];

    always #5 clk = ~clk;

    dig_div_bank #(.NCH(NCH), .BL_W(BL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ch_en      (ch_en),
        .resync     (resync),
        .burst_mode (burst_mode),
        .burst_len  (burst_len),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .divout     (divout),
        .tick       (tick),
        .cclk       (cclk)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample 0 follows the start edge; start is re-asserted before edge restart_at.
    task automatic burst_window(input int n, input int restart_at,
                                output int nb, output int nt0, output int nt1,
                                output int nd, output int done_at);
        nb = 0; nt0 = 0; nt1 = 0; nd = 0; done_at = -1;
        start = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            start = (i + 1 == restart_at) ? 1'b1 : 1'b0;
            if (busy)    nb++;
            if (tick[0]) nt0++;
            if (tick[1]) nt1++;
            if (done) begin
                nd++;
                done_at = i;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int nb, nt0, nt1, nd, done_at;

        vecs[0]  = {1'b1, 4'hF, 1'b0, 4'h1, 4'h1};
        vecs[1]  = {1'b1, 4'hF, 1'b0, 4'h2, 4'h2};
        vecs[2]  = {1'b1, 4'hF, 1'b0, 4'h3, 4'h1};
        vecs[3]  = {1'b1, 4'hF, 1'b0, 4'h4, 4'h4};
        vecs[4]  = {1'b1, 4'hF, 1'b0, 4'h5, 4'h1};
        vecs[5]  = {1'b0, 4'hF, 1'b0, 4'h5, 4'h0};
        vecs[6]  = {1'b0, 4'hF, 1'b0, 4'h5, 4'h0};
        vecs[7]  = {1'b0, 4'hF, 1'b0, 4'h5, 4'h0};
        vecs[8]  = {1'b0, 4'hF, 1'b0, 4'h5, 4'h0};
        vecs[9]  = {1'b0, 4'hF, 1'b0, 4'h5, 4'h0};
        vecs[10] = {1'b1, 4'hF, 1'b0, 4'h6, 4'h2};
        vecs[11] = {1'b1, 4'hF, 1'b0, 4'h7, 4'h1};
        vecs[12] = {1'b1, 4'hF, 1'b0, 4'h8, 4'h8};
        vecs[13] = {1'b1, 4'hB, 1'b0, 4'h9, 4'h1};
        vecs[14] = {1'b1, 4'hB, 1'b0, 4'hA, 4'h2};
        vecs[15] = {1'b1, 4'hB, 1'b0, 4'hB, 4'h1};
        vecs[16] = {1'b1, 4'hB, 1'b0, 4'h8, 4'h0};
        vecs[17] = {1'b1, 4'hB, 1'b0, 4'h9, 4'h1};
        vecs[18] = {1'b1, 4'hF, 1'b0, 4'hE, 4'h2};
        vecs[19] = {1'b1, 4'hF, 1'b0, 4'hF, 4'h1};
        vecs[20] = {1'b1, 4'hF, 1'b0, 4'h0, 4'h0};
        vecs[21] = {1'b1, 4'hF, 1'b0, 4'h1, 4'h1};
        vecs[22] = {1'b1, 4'hF, 1'b1, 4'h0, 4'h0};
        vecs[23] = {1'b1, 4'hF, 1'b0, 4'h1, 4'h1};

        rst = 1'b1; en = 1'b0; ch_en = 4'hF; resync = 1'b0;
        burst_mode = 1'b0; burst_len = '0; start = 1'b0;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_divout", divout, 0);
        check("rst_tick", tick, 0);
        check("rst_cclk", cclk, 0);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            en     = vecs[i].en;
            ch_en  = vecs[i].ch_en;
            resync = vecs[i].resync;
            step();
            check($sformatf("vec%0d_divout", i), divout, vecs[i].exp_div);
            check($sformatf("vec%0d_tick", i), tick, vecs[i].exp_tick);
            check($sformatf("vec%0d_cclk", i), cclk, vecs[i].exp_tick);
            check($sformatf("vec%0d_busy", i), busy, 0);
            check($sformatf("vec%0d_done", i), done, 0);
        end
        resync = 1'b0;
        en = 1'b1;
        ch_en = 4'hF;

        // Entering burst mode: one more free-run edge, then the counter is parked at 0.
        burst_mode = 1'b1;
        burst_len  = 8'd3;
        step();
        step();
        check("idle_park_divout", divout, 0);
        check("idle_park_busy", busy, 0);

        burst_window(10, 2, nb, nt0, nt1, nd, done_at);
        check("b3_busy_cycles", nb, 6);
        check("b3_tick0", nt0, 3);
        check("b3_tick1", nt1, 1);
        check("b3_done_count", nd, 1);
        check("b3_done_at", done_at, 6);
        check("b3_after_divout", divout, 0);
        check("b3_after_busy", busy, 0);

        burst_len = 8'd0;
        burst_window(4, -1, nb, nt0, nt1, nd, done_at);
        check("b0_busy_cycles", nb, 0);
        check("b0_tick0", nt0, 0);
        check("b0_done_count", nd, 1);
        check("b0_done_at", done_at, 0);

        burst_len = 8'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        check("rs_busy_start", busy, 1);
        step();
        step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        check("rs_busy", busy, 0);
        check("rs_divout", divout, 0);
        check("rs_tick", tick, 0);
        nd = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done || busy) nd++;
        end
        check("rs_no_done", nd, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("mr_busy_before", busy, 1);
        rst = 1'b1;
        step();
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_divout", divout, 0);
        check("mr_tick", tick, 0);
        rst = 1'b0;
        burst_len = 8'd2;
        burst_window(6, -1, nb, nt0, nt1, nd, done_at);
        check("mr_b2_busy_cycles", nb, 4);
        check("mr_b2_tick0", nt0, 2);
        check("mr_b2_tick1", nt1, 1);
        check("mr_b2_done_count", nd, 1);
        check("mr_b2_done_at", done_at, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
